compr_byte_packer: RTL and testbench



---
 rtl/compr_byte_packer.sv | 183 ++++++++++++++++++
 tb/tb_compr_byte_packer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compr_byte_packer.sv
// Packs 1-16 bit code words LSB-first into bytes and writes them into the compr_ram ring.
// Define COMPR_PACK_STATS_EN to add the stall_cycles output.
module compr_byte_packer #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned CODE_W = 16,
    parameter int unsigned FCNT_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic [CODE_W-1:0] code_data,
    input  logic [4:0]        code_len,
    input  logic              frame_end,
    input  logic [ADDR_W-1:0] rd_ptr,
    output logic [7:0]        ram_data,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic              ram_wren,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_bytes
`ifdef COMPR_PACK_STATS_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    localparam int unsigned ACC_W = CODE_W + 8;

    typedef enum logic [1:0] {
        ST_PACK,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                code_ready_q;
    logic [7:0]          ram_data_q;
    logic [ADDR_W-1:0]   ram_wraddress_q;
    logic                ram_wren_q;
    logic                frame_done_q;
    logic [FCNT_W-1:0]   frame_bytes_q, frame_bytes_d;

    logic [4:0]          len_eff;
    logic [CODE_W-1:0]   code_mask;
    logic [ACC_W-1:0]    code_shift;
    logic [ADDR_W-1:0]   wr_inc;
    logic                full;
    logic                accept;
    logic                emit_whole;
    logic                emit_pad;
    logic                emit;

    assign len_eff = (code_len > 5'(CODE_W)) ? 5'(CODE_W) : code_len;

    always_comb begin
        code_mask = '0;
        for (int unsigned i = 0; i < CODE_W; i++) begin
            code_mask[i] = (i < 32'(len_eff));
        end
    end

    assign code_shift = ACC_W'(code_data & code_mask) << cnt_q;
    assign wr_inc     = wr_ptr_q + ADDR_W'(1);
    assign full       = (wr_inc == rd_ptr);
    // code_ready_q is only ever high in PACK with cnt < 8, so accept never overlaps an emit
    assign accept     = code_valid & code_ready_q;
    assign emit       = emit_whole | emit_pad;

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        wr_ptr_d      = wr_ptr_q;
        bcnt_d        = bcnt_q;
        frame_bytes_d = frame_bytes_q;
        emit_whole    = 1'b0;
        emit_pad      = 1'b0;

        case (state_q)
            ST_PACK: begin
                if (accept) begin
                    acc_d = acc_q | code_shift;
                    cnt_d = cnt_q + len_eff;
                    if (frame_end) begin
                        state_d = ST_FLUSH;
                    end
                end else if (cnt_q >= 5'd8 && !full) begin
                    emit_whole = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (cnt_q >= 5'd8) begin
                    emit_whole = !full;
                end else if (cnt_q != 5'd0) begin
                    emit_pad = !full;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_PACK;
                bcnt_d  = '0;
            end
            default: begin
                state_d = ST_PACK;
            end
        endcase

        if (emit_whole) begin
            acc_d = acc_q >> 8;
            cnt_d = cnt_q - 5'd8;
        end
        if (emit_pad) begin
            acc_d = '0;
            cnt_d = '0;
        end
        if (emit) begin
            wr_ptr_d = wr_inc;
            bcnt_d   = (&bcnt_q) ? bcnt_q : bcnt_q + FCNT_W'(1);
        end
        if (state_d == ST_DONE) begin
            frame_bytes_d = bcnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= ST_PACK;
            acc_q           <= '0;
            cnt_q           <= '0;
            wr_ptr_q        <= '0;
            bcnt_q          <= '0;
            code_ready_q    <= 1'b0;
            ram_data_q      <= '0;
            ram_wraddress_q <= '0;
            ram_wren_q      <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_bytes_q   <= '0;
        end else begin
            state_q         <= state_d;
            acc_q           <= acc_d;
            cnt_q           <= cnt_d;
            wr_ptr_q        <= wr_ptr_d;
            bcnt_q          <= bcnt_d;
            code_ready_q    <= (state_d == ST_PACK) && (cnt_d < 5'd8);
            ram_data_q      <= emit ? acc_q[7:0] : ram_data_q;
            ram_wraddress_q <= emit ? wr_ptr_q : ram_wraddress_q;
            ram_wren_q      <= emit;
            frame_done_q    <= (state_d == ST_DONE);
            frame_bytes_q   <= frame_bytes_d;
        end
    end

`ifdef COMPR_PACK_STATS_EN
    logic [15:0] stall_q;
    logic        stall_pend;

    assign stall_pend = full && (((state_q == ST_PACK) && (cnt_q >= 5'd8)) ||
                                 ((state_q == ST_FLUSH) && (cnt_q != 5'd0)));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (stall_pend && !(&stall_q)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign code_ready    = code_ready_q;
    assign ram_data      = ram_data_q;
    assign ram_wraddress = ram_wraddress_q;
    assign ram_wren      = ram_wren_q;
    assign frame_done    = frame_done_q;
    assign frame_bytes   = frame_bytes_q;

endmodule

// File: tb/tb_compr_byte_packer.sv
// Self-checking bench for compr_byte_packer: directed scenarios plus random codes against a bit-queue model.
module tb_compr_byte_packer;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned CODE_W = 16;
    localparam int unsigned FCNT_W = 16;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              code_valid;
    logic              code_ready;
    logic [CODE_W-1:0] code_data;
    logic [4:0]        code_len;
    logic              frame_end;
    logic [ADDR_W-1:0] rd_ptr;
    logic [7:0]        ram_data;
    logic [ADDR_W-1:0] ram_wraddress;
    logic              ram_wren;
    logic              frame_done;
    logic [FCNT_W-1:0] frame_bytes;
`ifdef COMPR_PACK_STATS_EN
    logic [15:0]       stall_cycles;
`endif

    always #5 clock = ~clock;

    compr_byte_packer #(
        .ADDR_W(ADDR_W),
        .CODE_W(CODE_W),
        .FCNT_W(FCNT_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .code_valid   (code_valid),
        .code_ready   (code_ready),
        .code_data    (code_data),
        .code_len     (code_len),
        .frame_end    (frame_end),
        .rd_ptr       (rd_ptr),
        .ram_data     (ram_data),
        .ram_wraddress(ram_wraddress),
        .ram_wren     (ram_wren),
        .frame_done   (frame_done),
        .frame_bytes  (frame_bytes)
`ifdef COMPR_PACK_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: the stream as a queue of bits, expected frame sizes as a queue of counts.
    bit                bitq[$];
    int unsigned       fdq[$];
    int unsigned       frame_bits;
    int unsigned       exp_addr;
    int unsigned       nwrites;
    int unsigned       nframes;
    int unsigned       frames_sent;
    logic [7:0]        last_data;
    logic [ADDR_W-1:0] last_addr;
    logic [FCNT_W-1:0] last_fbytes;
    logic [7:0]        mon_byte;
    bit                rd_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (ram_wren === 1'b1) begin
            chk("wr_bits_avail", 32'(bitq.size() >= 8), 32'd1);
            if (bitq.size() >= 8) begin
                for (int i = 0; i < 8; i++) mon_byte[i] = bitq.pop_front();
                chk("wr_data", 32'(ram_data), 32'(mon_byte));
            end
            chk("wr_addr", 32'(ram_wraddress), 32'(ADDR_W'(exp_addr)));
            last_data = ram_data;
            last_addr = ram_wraddress;
            exp_addr++;
            nwrites++;
        end
        if (frame_done === 1'b1) begin
            chk("frame_pending", 32'(fdq.size() > 0), 32'd1);
            if (fdq.size() > 0) chk("frame_bytes", 32'(frame_bytes), fdq.pop_front());
            chk("ready_in_done", 32'(code_ready), 32'd0);
            last_fbytes = frame_bytes;
            nframes++;
        end
    end

    task automatic tick();
        @(negedge clock);
        if (rd_en && rd_ptr != ADDR_W'(exp_addr) && $urandom_range(0, 3) == 0)
            rd_ptr = ADDR_W'(rd_ptr + 1);
    endtask

    task automatic model_accept(input logic [CODE_W-1:0] d, input logic [4:0] l, input logic fe);
        int unsigned n;
        n = (l > 5'd16) ? 16 : int'(l);
        for (int unsigned i = 0; i < n; i++) bitq.push_back(d[i]);
        frame_bits += n;
        if (fe) begin
            while (frame_bits % 8 != 0) begin
                bitq.push_back(1'b0);
                frame_bits++;
            end
            fdq.push_back(frame_bits / 8);
            frame_bits = 0;
            frames_sent++;
        end
    endtask

    task automatic send(input logic [CODE_W-1:0] d, input logic [4:0] l, input logic fe);
        code_valid = 1'b1;
        code_data  = d;
        code_len   = l;
        frame_end  = fe;
        for (int c = 0; c < 4000 && code_ready !== 1'b1; c++) tick();
        if (code_ready === 1'b1) model_accept(d, l, fe);
        else chk("accept_timeout", 32'(code_ready), 32'd1);
        tick();
        code_valid = 1'b0;
        frame_end  = 1'b0;
        code_data  = '0;
        code_len   = '0;
    endtask

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget && (fdq.size() != 0 || bitq.size() != 0); c++) tick();
        chk("idle", 32'(fdq.size() + bitq.size()), 32'd0);
        tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(code_ready), 32'd0);
        chk({tag, "_wren"}, 32'(ram_wren), 32'd0);
        chk({tag, "_data"}, 32'(ram_data), 32'd0);
        chk({tag, "_addr"}, 32'(ram_wraddress), 32'd0);
        chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
        chk({tag, "_fbytes"}, 32'(frame_bytes), 32'd0);
`ifdef COMPR_PACK_STATS_EN
        chk({tag, "_stall"}, 32'(stall_cycles), 32'd0);
`endif
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        code_valid = 1'b0;
        frame_end  = 1'b0;
        code_data  = '0;
        code_len   = '0;
        rd_en      = 1'b0;
        rd_ptr     = '0;
        tick();
        chk_zero("rst");
        tick();
        bitq.delete();
        fdq.delete();
        frame_bits  = 0;
        exp_addr    = 0;
        nwrites     = 0;
        nframes     = 0;
        frames_sent = 0;
        reset_n     = 1'b1;
    endtask

    initial begin
        int unsigned nw0;
        logic [15:0] s0;
        logic [4:0]  rl;
        logic        rf;

        s0 = '0;
        do_reset();

        // Two codes completing one byte
        send(16'h0005, 5'd3, 1'b0);
        send(16'h001F, 5'd5, 1'b0);
        wait_idle(50);
        chk("t1_nwr", nwrites, 32'd1);
        chk("t1_data", 32'(last_data), 32'h0FD);
        chk("t1_addr", 32'(last_addr), 32'd0);
        chk("t1_nframe", nframes, 32'd0);

        // 16-bit code closing a frame
        do_reset();
        send(16'hABCD, 5'd16, 1'b1);
        chk("t2_ready_flush", 32'(code_ready), 32'd0);
        wait_idle(50);
        chk("t2_nwr", nwrites, 32'd2);
        chk("t2_data", 32'(last_data), 32'h0AB);
        chk("t2_addr", 32'(last_addr), 32'd1);
        chk("t2_nframe", nframes, 32'd1);
        chk("t2_fbytes", 32'(last_fbytes), 32'd2);

        // Padded partial byte
        do_reset();
        send(16'h0003, 5'd2, 1'b1);
        wait_idle(50);
        chk("t3_data", 32'(last_data), 32'h003);
        chk("t3_fbytes", 32'(last_fbytes), 32'd1);

        // Ring fills with rd_ptr held at 0, then drains after the reader moves
        do_reset();
        for (int i = 0; i < 512; i++) send(16'($urandom), 5'd8, 1'b0);
        repeat (10) tick();
        chk("t4_nwr_full", nwrites, 32'd511);
        chk("t4_last_addr", 32'(last_addr), 32'd510);
        chk("t4_wren_full", 32'(ram_wren), 32'd0);
        chk("t4_ready_full", 32'(code_ready), 32'd0);
`ifdef COMPR_PACK_STATS_EN
        s0 = stall_cycles;
        repeat (5) tick();
        chk("t4_stall_inc", 32'(stall_cycles - s0), 32'd5);
`endif
        rd_ptr = ADDR_W'(100);
        for (int i = 0; i < 88; i++) send(16'($urandom), 5'd8, 1'b0);
        wait_idle(200);
        chk("t4_nwr", nwrites, 32'd600);
        chk("t4_wrap_addr", 32'(last_addr), 32'd87);

        // Masking of dirty upper bits, and oversize length
        do_reset();
        send(16'hFFFF, 5'd3, 1'b0);
        send(16'h0000, 5'd5, 1'b0);
        wait_idle(50);
        chk("t5_mask", 32'(last_data), 32'h007);
        send(16'h1234, 5'd20, 1'b1);
        wait_idle(50);
        chk("t5_nwr", nwrites, 32'd3);
        chk("t5_data", 32'(last_data), 32'h012);
        chk("t5_fbytes", 32'(last_fbytes), 32'd3);

        // Reset with 5 bits pending must not write a pad byte
        do_reset();
        send(16'($urandom), 5'd5, 1'b0);
        repeat (3) tick();
        nw0 = nwrites;
        reset_n = 1'b0;
        tick();
        chk_zero("t6");
        tick();
        chk("t6_nowr", nwrites, nw0);
        do_reset();
        send(16'h0000, 5'd0, 1'b1);
        wait_idle(50);
        chk("t6_nframe", nframes, 32'd1);
        chk("t6_fbytes", 32'(last_fbytes), 32'd0);
        chk("t6_nwr", nwrites, 32'd0);

        // Random codes with a slow, random reader
        do_reset();
        rd_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rl = 5'($urandom_range(0, 20));
            rf = ($urandom_range(0, 7) == 0);
            send(16'($urandom), rl, rf);
        end
        send(16'($urandom), 5'($urandom_range(0, 16)), 1'b1);
        wait_idle(20000);
        chk("rand_frames", nframes, frames_sent);
        rd_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
